cube_calc: RTL and testbench



---
 rtl/cube_calc_pkg.sv | 24 ++
 rtl/cube_calc.sv | 129 ++++++++++++
 tb/tb_cube_calc.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/cube_calc_pkg.sv
// Shared definitions for the iterative cube unit: state encoding and the
// shift-add partial-product helper used by both accumulation passes.
package cube_calc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'h0,
        SQ   = 2'h1,
        CUBE = 2'h2
    } state_t;

    // Widest operand the helper handles; 3*WIDTH must not exceed this.
    localparam int PP_MAX_W = 96;

    // One shift-add term: the operand gated by a single multiplier bit,
    // shifted to that bit's weight.
    function automatic logic [PP_MAX_W-1:0] pp_term(
        input logic [PP_MAX_W-1:0] op,
        input logic                bit_i,
        input logic [7:0]          sh
    );
        return ({PP_MAX_W{bit_i}} & op) << sh;
    endfunction

endpackage

// File: rtl/cube_calc.sv
// Iterative integer cube y = x^3: one shift-add accumulator runs x*x over
// WIDTH edges, then (x*x)*x over another WIDTH edges.
module cube_calc
    import cube_calc_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               start_i,
    input  logic [WIDTH-1:0]   x_bi,
    output logic               busy_o,
    output logic               valid_o,
    output logic [3*WIDTH-1:0] y_bo,
    output logic [1:0]         dbg_state_o
);

    localparam int CTR_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int YW    = 3 * WIDTH;
    localparam int SQW   = 2 * WIDTH;

    // Handshake: start_i is honoured only in IDLE; the accepting edge latches
    // x_bi. busy_o is high while a multi-cycle result is pending, and valid_o
    // is a one-cycle pulse on the edge y_bo updates; the two never overlap.

    state_t             r_state, w_state_n;
    logic [WIDTH-1:0]   r_x, w_x_n;
    logic [YW-1:0]      r_acc, w_acc_n;
    logic [SQW-1:0]     r_sq, w_sq_n;
    logic [CTR_W-1:0]   r_ctr, w_ctr_n;
    logic               r_busy, w_busy_n;
    logic               r_valid, w_valid_n;
    logic [YW-1:0]      r_y, w_y_n;

    logic               w_last;
    logic               w_bit;
    logic [YW-1:0]      w_opnd;
    logic [YW-1:0]      w_pp;
    logic [YW-1:0]      w_sum;

    assign w_last = (r_ctr == CTR_W'(WIDTH - 1));
    assign w_bit  = r_x[r_ctr];
    assign w_opnd = (r_state == SQ) ? YW'(r_x) : YW'(r_sq);
    assign w_pp   = YW'(pp_term(PP_MAX_W'(w_opnd), w_bit, 8'(r_ctr)));
    assign w_sum  = r_acc + w_pp;

    always_comb begin
        w_state_n = r_state;
        w_x_n     = r_x;
        w_acc_n   = r_acc;
        w_sq_n    = r_sq;
        w_ctr_n   = r_ctr;
        w_busy_n  = r_busy;
        w_valid_n = 1'b0;
        w_y_n     = r_y;

        case (r_state)
            IDLE: begin
                if (start_i) begin
                    if (x_bi < WIDTH'(2)) begin
                        // 0 and 1 are their own cubes: answer on the accepting edge.
                        w_y_n     = YW'(x_bi);
                        w_valid_n = 1'b1;
                    end else begin
                        w_x_n     = x_bi;
                        w_acc_n   = '0;
                        w_ctr_n   = '0;
                        w_busy_n  = 1'b1;
                        w_state_n = SQ;
                    end
                end
            end
            SQ: begin
                w_acc_n = w_sum;
                w_ctr_n = r_ctr + CTR_W'(1);
                if (w_last) begin
                    w_sq_n    = w_sum[SQW-1:0];
                    w_acc_n   = '0;
                    w_ctr_n   = '0;
                    w_state_n = CUBE;
                end
            end
            CUBE: begin
                w_acc_n = w_sum;
                w_ctr_n = r_ctr + CTR_W'(1);
                if (w_last) begin
                    w_y_n     = w_sum;
                    w_valid_n = 1'b1;
                    w_busy_n  = 1'b0;
                    w_acc_n   = '0;
                    w_ctr_n   = '0;
                    w_state_n = IDLE;
                end
            end
            default: begin
                w_busy_n  = 1'b0;
                w_state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
            r_x     <= '0;
            r_acc   <= '0;
            r_sq    <= '0;
            r_ctr   <= '0;
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
            r_y     <= '0;
        end else begin
            r_state <= w_state_n;
            r_x     <= w_x_n;
            r_acc   <= w_acc_n;
            r_sq    <= w_sq_n;
            r_ctr   <= w_ctr_n;
            r_busy  <= w_busy_n;
            r_valid <= w_valid_n;
            r_y     <= w_y_n;
        end
    end

    assign busy_o      = r_busy;
    assign valid_o     = r_valid;
    assign y_bo        = r_y;
    assign dbg_state_o = r_state;

endmodule

// File: tb/tb_cube_calc.sv
// Self-checking bench for cube_calc: directed vector table, multi-cycle
// corner sequences and random operands against an arithmetic cube model.
module tb_cube_calc;

    localparam int W  = 8;
    localparam int YW = 3 * W;

    logic          clk_i;
    logic          rst_ni;
    logic          start_i;
    logic [W-1:0]  x_bi;
    logic          busy_o;
    logic          valid_o;
    logic [YW-1:0] y_bo;
    logic [1:0]    dbg_state_o;

    int total;
    int bad;

    cube_calc #(.WIDTH(W)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .start_i     (start_i),
        .x_bi        (x_bi),
        .busy_o      (busy_o),
        .valid_o     (valid_o),
        .y_bo        (y_bo),
        .dbg_state_o (dbg_state_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [W-1:0]  x;
        logic [YW-1:0] y;
        int            edge_at;
        int            ign_at;
    } vec_t;

    vec_t vecs[7];

    function automatic longint model_cube(input longint x);
        return x * x * x;
    endfunction

    task automatic check(input string nm, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    // Issue one request at the current negedge and follow it to its result.
    task automatic run_op(input string nm, input logic [W-1:0] x,
                          input logic [YW-1:0] exp_y, input int exp_edge,
                          input int ign_at);
        int e;
        int busy_n;
        bit got;
        start_i = 1'b1;
        x_bi    = x;
        e       = -1;
        busy_n  = 0;
        got     = 1'b0;
        while (!got && e < 40) begin
            step();
            e++;
            start_i = ((e + 1) == ign_at);
            x_bi    = start_i ? W'(7) : W'($urandom_range(0, 255));
            if (busy_o) busy_n++;
            if (busy_o && valid_o) check({nm, " overlap"}, 1, 0);
            if (valid_o) got = 1'b1;
        end
        check({nm, " timeout"}, longint'(got), 1);
        check({nm, " edge"}, e, exp_edge);
        check({nm, " y"}, y_bo, exp_y);
        check({nm, " busy_cycles"}, busy_n, (exp_edge == 0) ? 0 : 2 * W);
    endtask

    initial begin
        int vedges[$];
        int k;
        logic [W-1:0] rx;
        total   = 0;
        bad     = 0;
        rst_ni  = 1'b0;
        start_i = 1'b0;
        x_bi    = '0;

        vecs[0] = '{x: 8'd5,   y: 24'd125,      edge_at: 16, ign_at: -1};
        vecs[1] = '{x: 8'd255, y: 24'hFD02FF,   edge_at: 16, ign_at: -1};
        vecs[2] = '{x: 8'd2,   y: 24'd8,        edge_at: 16, ign_at: -1};
        vecs[3] = '{x: 8'd0,   y: 24'd0,        edge_at: 0,  ign_at: -1};
        vecs[4] = '{x: 8'd1,   y: 24'd1,        edge_at: 0,  ign_at: -1};
        vecs[5] = '{x: 8'd3,   y: 24'd27,       edge_at: 16, ign_at: 5};
        vecs[6] = '{x: 8'd128, y: 24'd2097152,  edge_at: 16, ign_at: -1};

        repeat (3) @(negedge clk_i);
        check("reset busy", busy_o, 0);
        check("reset valid", valid_o, 0);
        check("reset y", y_bo, 0);
        check("reset state", dbg_state_o, 0);
        rst_ni = 1'b1;
        step();
        check("idle valid", valid_o, 0);

        for (int i = 0; i < 7; i++)
            run_op($sformatf("vec%0d", i), vecs[i].x, vecs[i].y,
                   vecs[i].edge_at, vecs[i].ign_at);

        // Reset in the middle of a computation aborts it without a result.
        start_i = 1'b1;
        x_bi    = 8'd9;
        step();
        start_i = 1'b0;
        repeat (7) step();
        check("pre-reset busy", busy_o, 1);
        #2 rst_ni = 1'b0;
        #1;
        check("abort busy", busy_o, 0);
        check("abort valid", valid_o, 0);
        check("abort y", y_bo, 0);
        check("abort state", dbg_state_o, 0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        k = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (valid_o || busy_o) k++;
        end
        check("post-abort quiet", k, 0);
        run_op("restart", 8'd4, 24'd64, 16, -1);

        // start_i held high: back-to-back operations every 2W+1 edges.
        start_i = 1'b1;
        x_bi    = 8'd6;
        for (int e = 0; e < 55; e++) begin
            step();
            if (busy_o && valid_o) check("held overlap", 1, 0);
            if (valid_o) begin
                vedges.push_back(e);
                check("held y", y_bo, 216);
            end
        end
        start_i = 1'b0;
        check("held pulses", vedges.size(), 3);
        if (vedges.size() > 0) check("held first", vedges[0], 2 * W);
        for (int i = 1; i < vedges.size(); i++)
            check("held period", vedges[i] - vedges[i-1], 2 * W + 1);
        k = 0;
        while (busy_o && k < 40) begin
            step();
            k++;
        end
        check("held drain", busy_o, 0);
        step();

        for (int i = 0; i < 200; i++) begin
            rx = W'($urandom_range(0, 255));
            if (i < 4) rx = W'(i % 2);
            run_op($sformatf("rand%0d x=%0d", i, rx), rx,
                   YW'(model_cube(longint'(rx))), (rx < 2) ? 0 : 2 * W, -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
